// File: rtl/fnv_hash_arbiter.sv
//-----------------------------------------------------------------------------
// fnv_hash_arbiter
//
// Two byte-stream requesters share a single FNV-1a 32-bit hash engine. A
// requester owns the engine for a whole message (first byte through the byte
// flagged last). Ownership alternates round-robin between messages. The
// finished digest is offered on a valid/ready port tagged with the owner ID.
//
// Optional feature macro: FNV_ARB_TIMEOUT_EN
//   When defined, an idle-cycle counter aborts a message whose owner stops
//   sending for TIMEOUT_CYCLES cycles. The partial hash is reported with
//   digest_err=1. When undefined, ABSORB waits indefinitely.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   reqN_valid/data/last   - requester N byte stream (N = 0, 1)
//   reqN_ready             - requester N byte accepted when valid & ready
//   digest_valid/ready     - digest handshake
//   digest, digest_id      - FNV-1a result and the requester that produced it
//   digest_err             - message truncated (MAX_LEN reached or timeout)
//   busy                   - engine is not in IDLE
//-----------------------------------------------------------------------------
module fnv_hash_arbiter #(
  parameter logic [31:0] OFFSET_BASIS   = 32'h811C9DC5,
  parameter logic [31:0] PRIME          = 32'h01000193,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        digest_valid,
  output logic [31:0] digest,
  output logic        digest_id,
  output logic        digest_err,
  input  logic        digest_ready,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ABSORB = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [15:0] MAX_LEN_C = MAX_LEN[15:0];

  // Elaboration-time parameter range checks.
  if ((MAX_LEN < 1) || (MAX_LEN > 65535)) begin : g_bad_max_len
    $error("fnv_hash_arbiter: MAX_LEN must be in 1..65535");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fnv_hash_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // One FNV-1a byte step; the product is truncated to 32 bits.
  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] mixed;
    mixed = h ^ {24'h000000, b};
    return mixed * PRIME;
  endfunction

  logic [1:0]  state_r, state_s;
  logic        owner_r, owner_s;
  logic        rr_ptr_r, rr_ptr_s;
  logic [31:0] hash_r, hash_s;
  logic [15:0] count_r, count_s;
  logic        req0_ready_r, req0_ready_s;
  logic        req1_ready_r, req1_ready_s;
  logic        digest_valid_r, digest_valid_s;
  logic [31:0] digest_r, digest_s;
  logic        digest_id_r, digest_id_s;
  logic        digest_err_r, digest_err_s;
  logic        busy_r, busy_s;

  logic        own_valid_s;
  logic [7:0]  own_data_s;
  logic        own_last_s;
  logic        own_ready_s;
  logic        accept_s;
  logic [15:0] count_inc_s;
  logic [31:0] hash_step_s;

`ifdef FNV_ARB_TIMEOUT_EN
  logic [31:0] timer_r, timer_s;
`endif

  // Owner stream selection and byte-accept detection.
  always_comb begin
    if (owner_r) begin
      own_valid_s = req1_valid;
      own_data_s  = req1_data;
      own_last_s  = req1_last;
      own_ready_s = req1_ready_r;
    end else begin
      own_valid_s = req0_valid;
      own_data_s  = req0_data;
      own_last_s  = req0_last;
      own_ready_s = req0_ready_r;
    end
    accept_s    = own_valid_s & own_ready_s;
    count_inc_s = count_r + 16'd1;
    hash_step_s = fnv_step(hash_r, own_data_s);
  end

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_s        = state_r;
    owner_s        = owner_r;
    rr_ptr_s       = rr_ptr_r;
    hash_s         = hash_r;
    count_s        = count_r;
    digest_valid_s = digest_valid_r;
    digest_s       = digest_r;
    digest_id_s    = digest_id_r;
    digest_err_s   = digest_err_r;
`ifdef FNV_ARB_TIMEOUT_EN
    timer_s        = timer_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (req0_valid | req1_valid) begin
          state_s = ST_ABSORB;
          // Contention is settled by the round-robin pointer.
          if (req0_valid & req1_valid) begin
            owner_s = rr_ptr_r;
          end else begin
            owner_s = req1_valid;
          end
          hash_s  = OFFSET_BASIS;
          count_s = 16'd0;
`ifdef FNV_ARB_TIMEOUT_EN
          timer_s = 32'd0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ABSORB: begin
        if (accept_s) begin
          hash_s  = hash_step_s;
          count_s = count_inc_s;
`ifdef FNV_ARB_TIMEOUT_EN
          timer_s = 32'd0;
`endif
          if (own_last_s) begin
            state_s        = ST_DONE;
            digest_valid_s = 1'b1;
            digest_s       = hash_step_s;
            digest_id_s    = owner_r;
            digest_err_s   = 1'b0;
          end else if (count_inc_s == MAX_LEN_C) begin
            // Truncated: the rest of the stream becomes a new message.
            state_s        = ST_DONE;
            digest_valid_s = 1'b1;
            digest_s       = hash_step_s;
            digest_id_s    = owner_r;
            digest_err_s   = 1'b1;
          end else begin
            state_s = ST_ABSORB;
          end
        end else begin
`ifdef FNV_ARB_TIMEOUT_EN
          if ((timer_r + 32'd1) >= TIMEOUT_CYCLES) begin
            state_s        = ST_DONE;
            digest_valid_s = 1'b1;
            digest_s       = hash_r;
            digest_id_s    = owner_r;
            digest_err_s   = 1'b1;
            timer_s        = 32'd0;
          end else begin
            timer_s = timer_r + 32'd1;
          end
`else
          state_s = ST_ABSORB;
`endif
        end
      end

      ST_DONE: begin
        if (digest_ready) begin
          state_s        = ST_IDLE;
          rr_ptr_s       = ~owner_r;
          digest_valid_s = 1'b0;
          digest_s       = 32'd0;
          digest_id_s    = 1'b0;
          digest_err_s   = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end

      default: begin
        state_s        = ST_IDLE;
        hash_s         = OFFSET_BASIS;
        count_s        = 16'd0;
        digest_valid_s = 1'b0;
        digest_s       = 32'd0;
        digest_id_s    = 1'b0;
        digest_err_s   = 1'b0;
      end
    endcase

    // Ready is registered from the next state, giving a 1-cycle grant latency.
    req0_ready_s = (state_s == ST_ABSORB) && (owner_s == 1'b0);
    req1_ready_s = (state_s == ST_ABSORB) && (owner_s == 1'b1);
    busy_s       = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      owner_r        <= 1'b0;
      rr_ptr_r       <= 1'b0;
      hash_r         <= OFFSET_BASIS;
      count_r        <= 16'd0;
      req0_ready_r   <= 1'b0;
      req1_ready_r   <= 1'b0;
      digest_valid_r <= 1'b0;
      digest_r       <= 32'd0;
      digest_id_r    <= 1'b0;
      digest_err_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      owner_r        <= owner_s;
      rr_ptr_r       <= rr_ptr_s;
      hash_r         <= hash_s;
      count_r        <= count_s;
      req0_ready_r   <= req0_ready_s;
      req1_ready_r   <= req1_ready_s;
      digest_valid_r <= digest_valid_s;
      digest_r       <= digest_s;
      digest_id_r    <= digest_id_s;
      digest_err_r   <= digest_err_s;
      busy_r         <= busy_s;
    end
  end

`ifdef FNV_ARB_TIMEOUT_EN
  // Idle-cycle counter for the stalled-owner timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 32'd0;
    end else begin
      timer_r <= timer_s;
    end
  end
`endif

  assign req0_ready   = req0_ready_r;
  assign req1_ready   = req1_ready_r;
  assign digest_valid = digest_valid_r;
  assign digest       = digest_r;
  assign digest_id    = digest_id_r;
  assign digest_err   = digest_err_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_fnv_hash_arbiter.sv
//-----------------------------------------------------------------------------
// tb_fnv_hash_arbiter
//
// Directed bench for fnv_hash_arbiter. Instance "dut" uses MAX_LEN=64 and
// TIMEOUT_CYCLES=8; instance "dut4" uses MAX_LEN=4 for truncation cases.
// Expected digests are FNV-1a reference values computed by hand.
//-----------------------------------------------------------------------------
module tb_fnv_hash_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_r0_valid, a_r0_last, a_r0_ready;
  logic [7:0]  a_r0_data;
  logic        a_r1_valid, a_r1_last, a_r1_ready;
  logic [7:0]  a_r1_data;
  logic        a_dv, a_id, a_err, a_dready, a_busy;
  logic [31:0] a_digest;

  logic        b_r0_valid, b_r0_last, b_r0_ready;
  logic [7:0]  b_r0_data;
  logic        b_r1_valid, b_r1_last, b_r1_ready;
  logic [7:0]  b_r1_data;
  logic        b_dv, b_id, b_err, b_dready, b_busy;
  logic [31:0] b_digest;

  int errors = 0;
  int checks = 0;

  logic [7:0]  foobar [6];
  logic [31:0] dg [2];
  logic        eg [2];
  int          idx;
  int          nd;
  int          waited;
  logic        acc;

  localparam logic [31:0] H_A      = 32'hE40C292C;
  localparam logic [31:0] H_FOOBAR = 32'hBF9CF968;
  localparam logic [31:0] H_FOOB   = 32'h3F5076EF;
  localparam logic [31:0] H_AR     = 32'h5D251EFA;

  fnv_hash_arbiter #(.MAX_LEN(64), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(a_r0_valid), .req0_data(a_r0_data), .req0_last(a_r0_last), .req0_ready(a_r0_ready),
    .req1_valid(a_r1_valid), .req1_data(a_r1_data), .req1_last(a_r1_last), .req1_ready(a_r1_ready),
    .digest_valid(a_dv), .digest(a_digest), .digest_id(a_id), .digest_err(a_err),
    .digest_ready(a_dready), .busy(a_busy)
  );

  fnv_hash_arbiter #(.MAX_LEN(4), .TIMEOUT_CYCLES(8)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(b_r0_valid), .req0_data(b_r0_data), .req0_last(b_r0_last), .req0_ready(b_r0_ready),
    .req1_valid(b_r1_valid), .req1_data(b_r1_data), .req1_last(b_r1_last), .req1_ready(b_r1_ready),
    .digest_valid(b_dv), .digest(b_digest), .digest_id(b_id), .digest_err(b_err),
    .digest_ready(b_dready), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Hard time limit in case the run stalls.
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    dg = '{32'd0, 32'd0};
    eg = '{1'b0, 1'b0};
    reset = 1'b1;
    a_r0_valid = 1'b0; a_r0_data = 8'h00; a_r0_last = 1'b0;
    a_r1_valid = 1'b0; a_r1_data = 8'h00; a_r1_last = 1'b0;
    a_dready = 1'b0;
    b_r0_valid = 1'b0; b_r0_data = 8'h00; b_r0_last = 1'b0;
    b_r1_valid = 1'b0; b_r1_data = 8'h00; b_r1_last = 1'b0;
    b_dready = 1'b0;
    tick();
    tick();

    // Reset state
    chk1("rst_dv", a_dv, 1'b0);
    chk32("rst_digest", a_digest, 32'd0);
    chk1("rst_id", a_id, 1'b0);
    chk1("rst_err", a_err, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_r0_ready", a_r0_ready, 1'b0);
    chk1("rst_r1_ready", a_r1_ready, 1'b0);
    chk1("rst_b_busy", b_busy, 1'b0);
    reset = 1'b0;

    // Req0 single byte "a"
    a_dready = 1'b1;
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b1;
    tick();
    chk1("t1_grant_r0_ready", a_r0_ready, 1'b1);
    chk1("t1_grant_dv", a_dv, 1'b0);
    chk1("t1_grant_busy", a_busy, 1'b1);
    tick();
    a_r0_valid = 1'b0; a_r0_last = 1'b0;
    chk1("t1_dv", a_dv, 1'b1);
    chk32("t1_digest", a_digest, H_A);
    chk1("t1_id", a_id, 1'b0);
    chk1("t1_err", a_err, 1'b0);
    chk1("t1_r0_ready_drop", a_r0_ready, 1'b0);
    tick();
    chk1("t1_dv_drop", a_dv, 1'b0);
    chk1("t1_idle", a_busy, 1'b0);

    // Req1 "foobar" while req0 also waits; priority now belongs to req1
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b1;
    a_r1_valid = 1'b1; a_r1_data = foobar[0]; a_r1_last = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      a_r1_data = foobar[i];
      a_r1_last = (i == 5);
      chk1("t2_r1_ready", a_r1_ready, 1'b1);
      chk1("t2_r0_ready", a_r0_ready, 1'b0);
      tick();
    end
    a_r1_valid = 1'b0; a_r1_last = 1'b0;
    chk1("t2_dv", a_dv, 1'b1);
    chk32("t2_digest", a_digest, H_FOOBAR);
    chk1("t2_id", a_id, 1'b1);
    chk1("t2_err", a_err, 1'b0);
    chk1("t2_r1_ready_drop", a_r1_ready, 1'b0);
    tick();
    chk1("t2_dv_drop", a_dv, 1'b0);
    tick();
    chk1("t2b_r0_grant", a_r0_ready, 1'b1);
    tick();
    a_r0_valid = 1'b0; a_r0_last = 1'b0;
    chk1("t2b_dv", a_dv, 1'b1);
    chk32("t2b_digest", a_digest, H_A);
    chk1("t2b_id", a_id, 1'b0);
    tick();
    chk1("t2b_idle", a_busy, 1'b0);

    // Both requesters valid continuously from reset: ids alternate
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b1;
    a_r1_valid = 1'b1; a_r1_data = 8'h61; a_r1_last = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 8 && a_dv !== 1'b1; k++) tick();
      chk1("t3_dv", a_dv, 1'b1);
      chk1("t3_id", a_id, m[0]);
      chk32("t3_digest", a_digest, H_A);
      tick();
    end
    a_r0_valid = 1'b0; a_r0_last = 1'b0;
    a_r1_valid = 1'b0; a_r1_last = 1'b0;
    tick();

    // Digest held in DONE for 10 cycles while req1 is waiting
    a_dready = 1'b0;
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b1;
    a_r1_valid = 1'b1; a_r1_data = 8'h66; a_r1_last = 1'b1;
    tick();
    tick();
    a_r0_valid = 1'b0; a_r0_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("t5_dv", a_dv, 1'b1);
      chk32("t5_digest", a_digest, H_A);
      chk1("t5_id", a_id, 1'b0);
      chk1("t5_err", a_err, 1'b0);
      chk1("t5_r0_ready", a_r0_ready, 1'b0);
      chk1("t5_r1_ready", a_r1_ready, 1'b0);
      chk1("t5_busy", a_busy, 1'b1);
      tick();
    end
    a_dready = 1'b1;
    tick();
    a_r1_valid = 1'b0; a_r1_last = 1'b0;
    chk1("t5_dv_drop", a_dv, 1'b0);
    tick();
    chk1("t5_idle", a_busy, 1'b0);

    // Reset pulse mid-ABSORB discards the partial message
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b0;
    tick();
    tick();
    a_r0_valid = 1'b0;
    tick();
    tick();
    chk1("t6_absorb_busy", a_busy, 1'b1);
    chk1("t6_absorb_dv", a_dv, 1'b0);
    reset = 1'b1;
    tick();
    chk1("t6_rst_busy", a_busy, 1'b0);
    chk1("t6_rst_r0_ready", a_r0_ready, 1'b0);
    chk1("t6_rst_dv", a_dv, 1'b0);
    chk32("t6_rst_digest", a_digest, 32'd0);
    chk1("t6_rst_err", a_err, 1'b0);
    reset = 1'b0;
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b1;
    tick();
    tick();
    a_r0_valid = 1'b0; a_r0_last = 1'b0;
    chk1("t6_fresh_dv", a_dv, 1'b1);
    chk32("t6_fresh_digest", a_digest, H_A);
    chk1("t6_fresh_err", a_err, 1'b0);
    tick();

    // Owner stalls after one non-final byte
    a_r0_valid = 1'b1; a_r0_data = 8'h61; a_r0_last = 1'b0;
    tick();
    tick();
    a_r0_valid = 1'b0;
`ifdef FNV_ARB_TIMEOUT_EN
    waited = 0;
    for (int k = 0; k < 20 && a_dv !== 1'b1; k++) begin
      tick();
      waited++;
    end
    chk32("to_wait", waited, 32'd8);
    chk1("to_dv", a_dv, 1'b1);
    chk32("to_digest", a_digest, H_A);
    chk1("to_err", a_err, 1'b1);
    chk1("to_id", a_id, 1'b0);
    tick();
    chk1("to_idle", a_busy, 1'b0);
`else
    repeat (20) tick();
    chk1("stall_dv", a_dv, 1'b0);
    chk1("stall_busy", a_busy, 1'b1);
    chk1("stall_r0_ready", a_r0_ready, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif

    // MAX_LEN=4 truncation of "foobar", remainder re-arbitrated as "ar"
    b_dready = 1'b1;
    idx = 0;
    nd = 0;
    for (int k = 0; k < 40 && nd < 2; k++) begin
      b_r0_valid = (idx < 6);
      b_r0_data  = (idx < 6) ? foobar[idx] : 8'h00;
      b_r0_last  = (idx == 5);
      acc = b_r0_valid & b_r0_ready;
      if (b_dv === 1'b1) begin
        dg[nd] = b_digest;
        eg[nd] = b_err;
        nd++;
      end
      tick();
      if (acc) idx++;
    end
    b_r0_valid = 1'b0; b_r0_last = 1'b0;
    chk32("t4_count", nd, 32'd2);
    chk32("t4_trunc_digest", dg[0], H_FOOB);
    chk1("t4_trunc_err", eg[0], 1'b1);
    chk32("t4_rest_digest", dg[1], H_AR);
    chk1("t4_rest_err", eg[1], 1'b0);
    chk32("t4_bytes_used", idx, 32'd6);
    tick();
    chk1("t4_idle", b_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
